// File: rtl/dfa_stream_ctx_mgr.sv
// dfa_stream_ctx_mgr: per-stream DFA state save/restore with saturating match counters.
// Define MULTI_MATCH_CNT_EN to count every accept in a packet instead of at most one.
module dfa_stream_ctx_mgr #(
  parameter int NUM_STREAMS = 64,
  parameter int SID_W       = 6,
  parameter int STATE_W     = 11,
  parameter int CNT_W       = 16,
  parameter int DFA_LAT     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sop,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               new_stream,
  input  logic               enable,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic               eop,
  output logic               in_ready,
  output logic               done,
  output logic               fired,
  output logic [CNT_W-1:0]   total_count,
  input  logic [SID_W-1:0]   cnt_rd_sid,
  output logic [CNT_W-1:0]   cnt_rd_data,
  output logic [7:0]         dfa_char,
  output logic               dfa_char_vld,
  output logic [STATE_W-1:0] dfa_state_in,
  output logic               dfa_state_in_vld,
  input  logic [STATE_W-1:0] dfa_state_out,
  input  logic               dfa_accept
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, DRAIN = 3'd3, COMMIT = 3'd4;

  logic [2:0]             st_q, st_d, dcnt_q, dcnt_d;
  logic [SID_W-1:0]       sid_q, sid_d;
  logic                   en_q, en_d, new_q, new_d, fired_q, fired_d;
  logic [7:0]             char_q, char_d;
  logic                   char_vld_q, char_vld_d;
  logic [STATE_W-1:0]     so_q;
  logic                   acc_q;
  logic [NUM_STREAMS-1:0] known_q, known_d;
  logic [CNT_W-1:0]       cnt_q [NUM_STREAMS];
  logic [CNT_W-1:0]       total_q, total_d, rd_q, rd_d, inc, cnt_new;
  logic [STATE_W-1:0]     ram [NUM_STREAMS];
  logic                   hit, match, commit_wr;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign hit       = acc_q & (st_q == RUN || st_q == DRAIN || st_q == COMMIT);
  assign commit_wr = (st_q == COMMIT) & en_q;

`ifdef MULTI_MATCH_CNT_EN
  logic [CNT_W-1:0] mm_q, mm_d;
  always_comb begin
    inc   = sat_add(mm_q, {{(CNT_W-1){1'b0}}, hit});
    mm_d  = (st_q == RUN || st_q == DRAIN) ? inc : '0;
    match = |inc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mm_q <= '0;
    else mm_q <= mm_d;
`else
  logic pm_q, pm_d, pm_eff;
  always_comb begin
    pm_eff = pm_q | hit;
    pm_d   = (st_q == RUN || st_q == DRAIN) ? pm_eff : 1'b0;
    inc    = {{(CNT_W-1){1'b0}}, pm_eff};
    match  = pm_eff;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pm_q <= 1'b0;
    else pm_q <= pm_d;
`endif

  always_comb begin
    st_d    = st_q;
    sid_d   = sid_q;
    en_d    = en_q;
    new_d   = new_q;
    fired_d = fired_q;
    dcnt_d  = dcnt_q;
    known_d = known_q;
    case (st_q)
      IDLE: if (sop) begin
        st_d    = LOAD;
        sid_d   = stream_id;
        en_d    = enable;
        new_d   = new_stream;
        fired_d = 1'b0;
      end
      LOAD: st_d = RUN;
      RUN: if (eop) begin
        st_d   = DRAIN;
        dcnt_d = '0;
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 3'd1;
        st_d   = (dcnt_q == 3'(DFA_LAT)) ? COMMIT : DRAIN;
      end
      COMMIT: begin
        st_d    = IDLE;
        fired_d = en_q & match;
        if (en_q) known_d[sid_q] = 1'b1;
      end
      default: st_d = IDLE;
    endcase
    char_d     = char_in;
    char_vld_d = (st_q == RUN) & char_in_vld;
    cnt_new    = sat_add(cnt_q[sid_q], inc);
    total_d    = commit_wr ? sat_add(total_q, inc) : total_q;
    // bypass so a read of the stream being committed sees the new count next cycle
    rd_d       = (commit_wr && cnt_rd_sid == sid_q) ? cnt_new : cnt_q[cnt_rd_sid];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      sid_q      <= '0;
      en_q       <= 1'b0;
      new_q      <= 1'b0;
      fired_q    <= 1'b0;
      dcnt_q     <= '0;
      char_q     <= '0;
      char_vld_q <= 1'b0;
      so_q       <= '0;
      acc_q      <= 1'b0;
      known_q    <= '0;
      total_q    <= '0;
      rd_q       <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) cnt_q[i] <= '0;
    end else begin
      st_q       <= st_d;
      sid_q      <= sid_d;
      en_q       <= en_d;
      new_q      <= new_d;
      fired_q    <= fired_d;
      dcnt_q     <= dcnt_d;
      char_q     <= char_d;
      char_vld_q <= char_vld_d;
      so_q       <= dfa_state_out;
      acc_q      <= dfa_accept;
      known_q    <= known_d;
      total_q    <= total_d;
      rd_q       <= rd_d;
      if (commit_wr) cnt_q[sid_q] <= cnt_new;
    end
  end

  always_ff @(posedge clk)
    if (commit_wr) ram[sid_q] <= so_q;

  assign in_ready         = (st_q == IDLE) || (st_q == RUN);
  assign done             = (st_q == COMMIT);
  assign fired            = (st_q == COMMIT) ? (en_q & match) : fired_q;
  assign total_count      = total_q;
  assign cnt_rd_data      = rd_q;
  assign dfa_char         = char_q;
  assign dfa_char_vld     = char_vld_q;
  assign dfa_state_in_vld = (st_q == LOAD);
  assign dfa_state_in     = (new_q || !known_q[sid_q]) ? '0 : ram[sid_q];
endmodule
